// File: rtl/mult_seq_ctrl.sv
// Multi-cycle unsigned shift-and-add multiplier controller for MULTU (HI/LO).
// Sequences one shared external LEN+1 bit adder and does no addition itself.
module mult_seq_ctrl #(
   parameter int LEN = 32
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_start,
   input  logic           i_abort,
   input  logic [LEN-1:0] i_mcand,
   input  logic [LEN-1:0] i_mplier,
   output logic [LEN:0]   o_add_a,
   output logic [LEN:0]   o_add_b,
   input  logic [LEN:0]   i_add_sum,
   output logic           o_busy,
   output logic           o_done,
   output logic [LEN-1:0] o_hi,
   output logic [LEN-1:0] o_lo
);

   // state | meaning
   // IDLE  | waiting for start; o_hi/o_lo hold the last completed product
   // RUN   | one shift-and-add iteration per cycle, LEN cycles total
   // DONE  | result presented with o_done for one cycle

   localparam int CNT_W = $clog2(LEN) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [LEN-1:0]   mcand_r;
   logic [LEN:0]     acc_r;
   logic [LEN-1:0]   lo_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [LEN-1:0]   hi_out_r;
   logic [LEN-1:0]   lo_out_r;

   // acc_r[LEN] is always 0 ahead of an add, so the full register is the A operand
   assign o_add_a = acc_r;
   assign o_add_b = (state == RUN && lo_r[0]) ? {1'b0, mcand_r} : '0;
   assign o_busy  = busy_r;
   assign o_done  = done_r;
   assign o_hi    = hi_out_r;
   assign o_lo    = lo_out_r;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= IDLE;
         mcand_r  <= '0;
         acc_r    <= '0;
         lo_r     <= '0;
         cnt_r    <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         hi_out_r <= '0;
         lo_out_r <= '0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (i_start && !i_abort) begin
                  mcand_r <= i_mcand;
                  lo_r    <= i_mplier;
                  acc_r   <= '0;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (i_abort) begin
                  busy_r <= 1'b0;
                  state  <= IDLE;
               end else begin
                  acc_r <= {1'b0, i_add_sum[LEN:1]};
                  lo_r  <= {i_add_sum[0], lo_r[LEN-1:1]};
                  cnt_r <= cnt_r + CNT_W'(1);
                  if (cnt_r == CNT_W'(LEN - 1)) begin
                     // capture the post-shift product so it is valid alongside o_done
                     hi_out_r <= i_add_sum[LEN:1];
                     lo_out_r <= {i_add_sum[0], lo_r[LEN-1:1]};
                     done_r   <= 1'b1;
                     state    <= DONE;
                  end
               end
            end
            DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: stimulus pushes expected products,
// a negedge monitor pops and compares them whenever o_done is seen.
module tb_mult_seq_ctrl;

   localparam int LEN = 32;

   logic           clk = 1'b0;
   logic           i_reset;
   logic           i_start;
   logic           i_abort;
   logic [LEN-1:0] i_mcand;
   logic [LEN-1:0] i_mplier;
   logic [LEN:0]   o_add_a;
   logic [LEN:0]   o_add_b;
   logic [LEN:0]   i_add_sum;
   logic           o_busy;
   logic           o_done;
   logic [LEN-1:0] o_hi;
   logic [LEN-1:0] o_lo;

   typedef struct {
      logic [LEN-1:0] hi;
      logic [LEN-1:0] lo;
      int             cyc;
   } exp_t;

   exp_t           sb[$];
   int             vectors = 0;
   int             miscompares = 0;
   int             cyc = 0;
   logic           prev_done = 1'b0;
   logic [LEN-1:0] hold_hi = '0;
   logic [LEN-1:0] hold_lo = '0;

   mult_seq_ctrl #(.LEN(LEN)) dut (
      .i_clk    (clk),
      .i_reset  (i_reset),
      .i_start  (i_start),
      .i_abort  (i_abort),
      .i_mcand  (i_mcand),
      .i_mplier (i_mplier),
      .o_add_a  (o_add_a),
      .o_add_b  (o_add_b),
      .i_add_sum(i_add_sum),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_hi     (o_hi),
      .o_lo     (o_lo)
   );

   // the shared external adder
   assign i_add_sum = o_add_a + o_add_b;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (o_done === 1'b1) begin
         check("done_single_cycle", 64'(prev_done), 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(o_done), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result_hi", 64'(o_hi), 64'(e.hi));
            check("result_lo", 64'(o_lo), 64'(e.lo));
            check("done_latency", 64'(cyc), 64'(e.cyc));
         end
      end
      prev_done = (o_done === 1'b1);
   end

   // kind: 0 plain, 1 abort at kill_at, 2 reset at kill_at, 3 extra start at kill_at
   task automatic do_op(input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                        input int kill_at, input int kind);
      int   t;
      logic killed;
      logic [63:0] prod;
      exp_t e;
      t = 0;
      killed = 1'b0;
      while (o_busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("idle_wait", 64'(o_busy), 64'd0);
      i_start  = 1'b1;
      i_mcand  = a;
      i_mplier = b;
      if (kind == 0 || kind == 3) begin
         prod  = 64'(a) * 64'(b);
         e.hi  = prod[63:32];
         e.lo  = prod[31:0];
         e.cyc = cyc + 1 + LEN;
         sb.push_back(e);
         hold_hi = e.hi;
         hold_lo = e.lo;
      end
      for (int j = 1; j <= LEN && !killed; j++) begin
         @(negedge clk);
         i_start = 1'b0;
         if (j == 1) check("busy_after_start", 64'(o_busy), 64'd1);
         check("add_b_run", 64'(o_add_b), b[j-1] ? 64'(a) : 64'd0);
         if (j == kill_at) begin
            if (kind == 1 || kind == 2) begin
               if (kind == 1) i_abort = 1'b1;
               else i_reset = 1'b1;
               @(negedge clk);
               i_abort = 1'b0;
               i_reset = 1'b0;
               if (kind == 2) begin
                  hold_hi = '0;
                  hold_lo = '0;
               end
               check("kill_busy", 64'(o_busy), 64'd0);
               check("kill_done", 64'(o_done), 64'd0);
               check("kill_hi", 64'(o_hi), 64'(hold_hi));
               check("kill_lo", 64'(o_lo), 64'(hold_lo));
               killed = 1'b1;
            end else if (kind == 3) begin
               i_start  = 1'b1;
               i_mcand  = 32'd2;
               i_mplier = 32'd2;
            end
         end
      end
      if (i_start) begin
         @(negedge clk);
         i_start = 1'b0;
      end
   endtask

   initial begin
      int t;
      logic [LEN-1:0] a, b;
      int kind;
      i_reset  = 1'b1;
      i_start  = 1'b0;
      i_abort  = 1'b0;
      i_mcand  = '0;
      i_mplier = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(o_busy), 64'd0);
      check("reset_done", 64'(o_done), 64'd0);
      check("reset_hi", 64'(o_hi), 64'd0);
      check("reset_lo", 64'(o_lo), 64'd0);
      check("reset_add_a", 64'(o_add_a), 64'd0);
      check("reset_add_b", 64'(o_add_b), 64'd0);
      i_reset = 1'b0;
      @(negedge clk);

      do_op(32'd3, 32'd5, 0, 0);
      do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
      do_op(32'd7, 32'd9, 10, 3);
      do_op(32'd2, 32'd2, 0, 0);
      do_op(32'h12345678, 32'h9ABCDEF0, 12, 1);
      do_op(32'd11, 32'd13, 0, 0);
      do_op(32'h12345678, 32'h9ABCDEF0, 20, 2);

      // simultaneous start and abort in IDLE must not launch an operation
      @(negedge clk);
      i_start  = 1'b1;
      i_abort  = 1'b1;
      i_mcand  = 32'd5;
      i_mplier = 32'd5;
      @(negedge clk);
      i_start = 1'b0;
      i_abort = 1'b0;
      check("start_abort_busy", 64'(o_busy), 64'd0);
      @(negedge clk);
      check("start_abort_busy2", 64'(o_busy), 64'd0);

      do_op(32'd0, 32'hDEADBEEF, 0, 0);

      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 4))
            0: a = '0;
            1: a = '1;
            default: a = $urandom;
         endcase
         b = (n % 7 == 3) ? '1 : $urandom;
         kind = $urandom_range(0, 5);
         if (kind > 3) kind = 0;
         if (kind == 2) kind = 1;
         do_op(a, b, $urandom_range(1, LEN), kind);
      end

      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain_outstanding", 64'(sb.size()), 64'd0);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
